datamemory_arbiter: RTL and testbench
=====================================

Name: datamemory_arbiter

Overview:
- Two-port controller that shares the single big-endian, byte-addressed, 32-bit-word data memory between two requesters: port 0 is the CPU load/store unit and port 1 is the debug/DMA loader.
- It accepts word requests over valid/ready, checks alignment and range, and drives the memory's Address/WriteData/MemWrite/MemRead strobes for a fixed number of cycles.
- It returns read data or an error on a per-port response strobe.
- It sits between the datapath's memory stage and the data memory.

Parameters:
- MEM_BYTES, 8192, size of the data memory in bytes; the highest legal word address is MEM_BYTES-4.
- MEM_LATENCY, 1, number of cycles the memory strobe is held; read data is sampled at the edge ending the last strobe cycle; legal range 1..15.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_write  in  1  1 = store word, 0 = load word.
- req0_addr  in  32  byte address.
- req0_wdata  in  32  store data; [31:24] goes to the lowest byte address.
- resp0_valid  out  1  one-cycle response strobe for port 0.
- resp0_rdata  out  32  load data; 0 for stores and errors.
- resp0_err  out  1  misaligned or out-of-range request.
- req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, resp1_valid, resp1_rdata, resp1_err: same as port 0, for port 1.
- mem_address  out  32  to memory Address.
- mem_writedata  out  32  to memory WriteData.
- mem_memwrite  out  1  to memory MemWrite.
- mem_memread  out  1  to memory MemRead.
- mem_readdata  in  32  from memory ReadData.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is set so that port 0 wins the first tie.
  - Latched request registers are 0.
- States: IDLE, ACCESS, ERROR, RESP.
- IDLE:
  - reqN_ready = (state==IDLE) & grantN. This is combinational from valid and the pointer.
  - Only one ready is high at a time. A ready is never high outside IDLE.
  - With a single valid, that port is granted.
  - With both valid, the port not granted last wins. The pointer updates only on a grant.
  - On accept (valid & ready at the edge), the controller latches addr, wdata, write and the port id.
  - Next state is ERROR if addr[1:0] != 0 or addr > MEM_BYTES-4; otherwise ACCESS.
- ACCESS:
  - mem_address and mem_writedata are driven from the latches.
  - Exactly one of mem_memwrite / mem_memread is high, never both.
  - The state lasts exactly MEM_LATENCY cycles, counted by a down-counter of width clog2(MEM_LATENCY+1).
  - For loads, mem_readdata is captured at the edge that ends the last ACCESS cycle.
  - Next state is RESP.
- ERROR:
  - Lasts one cycle with no memory strobes; mem_address and mem_writedata stay 0.
  - Next state is RESP with err=1 and rdata=0.
- RESP:
  - respN_valid is high for exactly one cycle, only for the granted port, with rdata and err.
  - The other port's resp outputs stay 0.
  - There is no response backpressure; the requester must accept the strobe.
  - Next state is IDLE.
- Outside ACCESS: mem_address, mem_writedata and both strobes are 0. All resp outputs are 0 outside RESP.
- Latency:
  - Accept edge is T.
  - Strobes are high in cycles T+1..T+MEM_LATENCY.
  - resp_valid is high in cycle T+MEM_LATENCY+1.
  - IDLE is re-entered at T+MEM_LATENCY+2.
  - Error latency is 2 cycles (ERROR then RESP).
  - Peak throughput is one transaction per MEM_LATENCY+2 cycles.
- A requester may change or drop valid freely while not accepted. The request fields are ignored after the accept edge.
- A valid held through RESP is accepted in the following IDLE cycle, subject to arbitration.
- Reset asserted mid-transaction: the transaction is aborted, the next edge returns to IDLE with all strobes at 0, and no response is issued for the aborted request.
- Address arithmetic is unsigned 32-bit. addr = 0xFFFFFFFC is out of range (error), not wrapped.

Test Plan:
- Reset, then port 0 store addr 40 data 0x01020304 -> mem_memwrite high 1 cycle with mem_address 40; resp0_valid two cycles after accept, err=0, rdata=0.
- Port 0 load addr 40 after the store above -> resp0_rdata=0x01020304, err=0, mem_memread high exactly 1 cycle; load of pre-initialised addr 40 before any store returns 0x00000064.
- Both ports valid continuously with loads -> grants alternate 0,1,0,1; exactly one resp per grant, each to the correct port, never both ready in one cycle.
- Port 1 load addr 42 (misaligned) and addr 8192 (out of range) -> no memory strobes, resp1_valid with err=1, rdata=0, two cycles after accept.
- MEM_LATENCY=3, port 0 load -> mem_memread high 3 consecutive cycles, resp0_valid in cycle T+4, next accept no earlier than T+5.
- Reset asserted during ACCESS -> strobes 0 on the next cycle, no resp, and the first post-reset tie is granted to port 0.

Source files
------------

// File: rtl/datamemory_arbiter_if.sv
// datamemory_arbiter_if
//   Bundles every bus signal of the data-memory arbiter: the two requester
//   ports (valid/ready request channel plus a one-cycle response strobe) and
//   the word-wide data-memory interface.
//   slave  : seen from the arbiter (takes requests, drives the memory).
//   master : seen from the environment (requesters plus the memory model).
interface datamemory_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_write;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        resp0_valid;
  logic [31:0] resp0_rdata;
  logic        resp0_err;

  logic        req1_valid;
  logic        req1_ready;
  logic        req1_write;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        resp1_valid;
  logic [31:0] resp1_rdata;
  logic        resp1_err;

  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_readdata;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, resp0_valid, resp0_rdata, resp0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, resp1_valid, resp1_rdata, resp1_err,
    output mem_address, mem_writedata, mem_memwrite, mem_memread,
    input  mem_readdata
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
    input  mem_address, mem_writedata, mem_memwrite, mem_memread,
    output mem_readdata
  );
endinterface

// File: rtl/datamemory_arbiter.sv
// datamemory_arbiter
//   Shares one big-endian, byte-addressed, 32-bit-word data memory between
//   the CPU load/store unit (port 0) and the debug/DMA loader (port 1).
//   Requests are accepted one at a time with round-robin arbitration,
//   checked for alignment and range, then either run on the memory for
//   MEM_LATENCY cycles or turned straight into an error response.
// Ports
//   clock : system clock, rising edge active
//   reset : synchronous, active-high
//   bus   : datamemory_arbiter_if.slave (request/response ports 0 and 1,
//           memory Address/WriteData/MemWrite/MemRead/ReadData)
module datamemory_arbiter #(
  parameter int MEM_BYTES   = 8192,
  parameter int MEM_LATENCY = 1
) (
  input logic                 clock,
  input logic                 reset,
  datamemory_arbiter_if.slave bus
);

  localparam int              CntW    = $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [31:0]     MaxAddr = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR, RESP} state_t;

  state_t          state_q, state_d;
  logic            lastGrant_q, lastGrant_d;
  logic            port_q, port_d;
  logic            write_q, write_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        grant0, grant1, accept, badAddr;
  logic        selWrite;
  logic [31:0] selAddr, selWdata;
  logic        inAccess, inResp;

  // Round-robin grant: lastGrant_q names the port served most recently, so a
  // tie goes to the other one. Reset leaves it at port 1 so port 0 wins first.
  // Ready is held low during reset so every output reads 0 while it is held.
  always_comb begin
    grant0   = bus.req0_valid & (~bus.req1_valid | lastGrant_q);
    grant1   = bus.req1_valid & ~grant0;
    accept   = (state_q == IDLE) & ~reset & (grant0 | grant1);
    selWrite = grant1 ? bus.req1_write : bus.req0_write;
    selAddr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    selWdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
    // Unsigned compare, so addresses near 2^32 are rejected rather than wrapped.
    badAddr  = (selAddr[1:0] != 2'b00) | (selAddr > MaxAddr);
  end

  // State register and request latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      port_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      port_q      <= port_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic. rdata_q is cleared on accept so stores and errors
  // answer with 0; only a load that finishes ACCESS overwrites it.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    port_d      = port_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          lastGrant_d = grant1;
          port_d      = grant1;
          write_d     = selWrite;
          addr_d      = selAddr;
          wdata_d     = selWdata;
          rdata_d     = '0;
          err_d       = 1'b0;
          cnt_d       = CntInit;
          state_d     = badAddr ? ERROR : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CntOne) begin
          if (!write_q) begin
            rdata_d = bus.mem_readdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      ERROR: begin
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign inAccess = (state_q == ACCESS);
  assign inResp   = (state_q == RESP);

  assign bus.req0_ready    = accept & grant0;
  assign bus.req1_ready    = accept & grant1;

  assign bus.mem_address   = inAccess ? addr_q  : '0;
  assign bus.mem_writedata = inAccess ? wdata_q : '0;
  assign bus.mem_memwrite  = inAccess &  write_q;
  assign bus.mem_memread   = inAccess & ~write_q;

  assign bus.resp0_valid   = inResp & ~port_q;
  assign bus.resp0_rdata   = (inResp & ~port_q) ? rdata_q : '0;
  assign bus.resp0_err     = inResp & ~port_q & err_q;
  assign bus.resp1_valid   = inResp & port_q;
  assign bus.resp1_rdata   = (inResp & port_q) ? rdata_q : '0;
  assign bus.resp1_err     = inResp & port_q & err_q;

endmodule

// File: tb/tb_datamemory_arbiter.sv
// tb_datamemory_arbiter
//   Two arbiters share the bench: dutA with MEM_LATENCY=1 and dutB with
//   MEM_LATENCY=3, each with its own word memory whose unwritten words read
//   back as (word index * 10), so byte address 40 holds 0x64.
module tb_datamemory_arbiter;

  localparam int MEM_BYTES = 8192;
  localparam int LAT_A     = 1;
  localparam int WORDS     = MEM_BYTES / 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  datamemory_arbiter_if busA ();
  datamemory_arbiter_if busB ();

  datamemory_arbiter #(.MEM_BYTES(MEM_BYTES), .MEM_LATENCY(LAT_A)) dutA (
    .clock(clock), .reset(reset), .bus(busA)
  );
  datamemory_arbiter #(.MEM_BYTES(MEM_BYTES), .MEM_LATENCY(3)) dutB (
    .clock(clock), .reset(reset), .bus(busB)
  );

  // Memories seen by the two arbiters.
  bit [31:0] memA [WORDS];
  bit        wrA  [WORDS];
  bit [31:0] memB [WORDS];
  bit        wrB  [WORDS];

  function automatic logic [31:0] initWord(input int idx);
    return 32'(idx * 10);
  endfunction

  always @(posedge clock) begin
    if (busA.mem_memwrite) begin
      memA[busA.mem_address[12:2]] <= busA.mem_writedata;
      wrA[busA.mem_address[12:2]]  <= 1'b1;
    end
    if (busB.mem_memwrite) begin
      memB[busB.mem_address[12:2]] <= busB.mem_writedata;
      wrB[busB.mem_address[12:2]]  <= 1'b1;
    end
  end

  assign busA.mem_readdata = wrA[busA.mem_address[12:2]] ? memA[busA.mem_address[12:2]]
                                                         : initWord(int'(busA.mem_address[12:2]));
  assign busB.mem_readdata = wrB[busB.mem_address[12:2]] ? memB[busB.mem_address[12:2]]
                                                         : initWord(int'(busB.mem_address[12:2]));

  typedef struct packed {
    logic        rdy0;
    logic        rdy1;
    logic        mw;
    logic        mr;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        r0v;
    logic [31:0] r0d;
    logic        r0e;
    logic        r1v;
    logic [31:0] r1d;
    logic        r1e;
  } outs_t;

  typedef struct {
    bit          v0, w0;
    logic [31:0] a0, d0;
    bit          v1, w1;
    logic [31:0] a1, d1;
    outs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // Shadow of dutA's memory used by the reference model.
  bit [31:0] shadow [WORDS];
  bit        shWr   [WORDS];

  function automatic logic [31:0] modelLoad(input logic [31:0] addr);
    int idx;
    idx = int'(addr / 4);
    return shWr[idx] ? shadow[idx] : initWord(idx);
  endfunction

  function automatic void modelStore(input logic [31:0] addr, input logic [31:0] data);
    int idx;
    idx = int'(addr / 4);
    shadow[idx] = data;
    shWr[idx]   = 1'b1;
  endfunction

  function automatic outs_t mkOuts(input bit rdy0, rdy1, mw, mr,
                                   input logic [31:0] maddr, mwd,
                                   input bit r0v, input logic [31:0] r0d, input bit r0e,
                                   input bit r1v, input logic [31:0] r1d, input bit r1e);
    outs_t o;
    o.rdy0 = rdy0; o.rdy1 = rdy1; o.mw = mw; o.mr = mr;
    o.maddr = maddr; o.mwd = mwd;
    o.r0v = r0v; o.r0d = r0d; o.r0e = r0e;
    o.r1v = r1v; o.r1d = r1d; o.r1e = r1e;
    return o;
  endfunction

  function automatic outs_t sampleOuts(input bit useB);
    if (useB)
      return mkOuts(busB.req0_ready, busB.req1_ready, busB.mem_memwrite, busB.mem_memread,
                    busB.mem_address, busB.mem_writedata,
                    busB.resp0_valid, busB.resp0_rdata, busB.resp0_err,
                    busB.resp1_valid, busB.resp1_rdata, busB.resp1_err);
    return mkOuts(busA.req0_ready, busA.req1_ready, busA.mem_memwrite, busA.mem_memread,
                  busA.mem_address, busA.mem_writedata,
                  busA.resp0_valid, busA.resp0_rdata, busA.resp0_err,
                  busA.resp1_valid, busA.resp1_rdata, busA.resp1_err);
  endfunction

  task automatic applyStimulus(input bit useB, input bit v0, w0, input logic [31:0] a0, d0,
                               input bit v1, w1, input logic [31:0] a1, d1);
    if (useB) begin
      busB.req0_valid = v0; busB.req0_write = w0; busB.req0_addr = a0; busB.req0_wdata = d0;
      busB.req1_valid = v1; busB.req1_write = w1; busB.req1_addr = a1; busB.req1_wdata = d1;
    end else begin
      busA.req0_valid = v0; busA.req0_write = w0; busA.req0_addr = a0; busA.req0_wdata = d0;
      busA.req1_valid = v1; busA.req1_write = w1; busA.req1_addr = a1; busA.req1_wdata = d1;
    end
  endtask

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (rdy0 rdy1 mw mr addr wdata r0v r0d r0e r1v r1d r1e)",
               name, act, exp);
    end
  endtask

  task automatic addVec(input bit v0, w0, input logic [31:0] a0, d0,
                        input bit v1, w1, input logic [31:0] a1, d1, input outs_t exp);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  // Two cycles with reset held; the second one must show all outputs at 0.
  task automatic resetCycle();
    @(posedge clock); #1;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("reset A", sampleOuts(0), '0);
    checkOutput("reset B", sampleOuts(1), '0);
  endtask

  task automatic runTable(input string tag, input bit useB);
    foreach (vecs[i]) begin
      @(posedge clock); #1;
      reset = 1'b0;
      applyStimulus(useB, vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                    vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge clock);
      checkOutput($sformatf("%s row %0d", tag, i), sampleOuts(useB), vecs[i].exp);
    end
    vecs.delete();
  endtask

  function automatic logic [31:0] randAddr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel <= 6) return 32'(256 + 4 * $urandom_range(0, 15));
    if (sel == 7) return 32'(MEM_BYTES - 4);
    if (sel == 8) return 32'(256 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    case ($urandom_range(0, 2))
      0:       return 32'(MEM_BYTES);
      1:       return 32'hFFFF_FFFC;
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    outs_t Z;
    Z = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    resetCycle();

    // Directed sequence on dutA, one row per cycle.
    addVec(1,0,40,0,           0,0,0,0, mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,1,40,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,0,0,0, 1,32'h64,0, 0,0,0));
    addVec(1,1,40,32'h01020304,0,0,0,0, mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,1,0,40,32'h01020304, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,0,0,0, 1,0,0, 0,0,0));
    addVec(1,0,40,0,           0,0,0,0, mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,1,40,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,0,0,0, 1,32'h01020304,0, 0,0,0));
    addVec(0,0,0,0,            1,0,42,0, mkOuts(0,1,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, Z);
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,0,0,0, 0,0,0, 1,0,1));
    addVec(0,0,0,0,            1,0,8192,0, mkOuts(0,1,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, Z);
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,0,0,0, 0,0,0, 1,0,1));
    addVec(0,0,0,0,            1,1,32'hFFFFFFFC,32'hDEADBEEF, mkOuts(0,1,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, Z);
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,0,0,0, 0,0,0, 1,0,1));
    addVec(1,1,8188,32'hCAFEF00D, 0,0,0,0, mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,1,0,8188,32'hCAFEF00D, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,0,0,0, 1,0,0, 0,0,0));
    // Both ports held valid: port 0 was served last, so port 1 goes first.
    addVec(1,0,44,0,           1,0,8188,0, mkOuts(0,1,0,0,0,0, 0,0,0, 0,0,0));
    addVec(1,0,44,0,           1,0,8188,0, mkOuts(0,0,0,1,8188,0, 0,0,0, 0,0,0));
    addVec(1,0,44,0,           1,0,8188,0, mkOuts(0,0,0,0,0,0, 0,0,0, 1,32'hCAFEF00D,0));
    addVec(1,0,44,0,           1,0,8188,0, mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    addVec(1,0,44,0,           1,0,8188,0, mkOuts(0,0,0,1,44,0, 0,0,0, 0,0,0));
    addVec(1,0,44,0,           1,0,8188,0, mkOuts(0,0,0,0,0,0, 1,32'h6E,0, 0,0,0));
    addVec(1,0,44,0,           1,0,8188,0, mkOuts(0,1,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,1,8188,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,            0,0,0,0, mkOuts(0,0,0,0,0,0, 0,0,0, 1,32'hCAFEF00D,0));
    addVec(0,0,0,0,            0,0,0,0, Z);
    runTable("directed", 0);

    // The reference model knows what the directed sequence stored.
    modelStore(40, 32'h01020304);
    modelStore(8188, 32'hCAFEF00D);

    resetCycle();

    // Randomised traffic on dutA against a transaction-timeline model.
    begin
      bit          mBusy, mErr, mWr;
      int          mAcc, mLast, mPort, rel, win;
      logic [31:0] mAddr, mWd, mData;
      bit          v0, w0, v1, w1;
      logic [31:0] a0, d0, a1, d1;
      outs_t       exp;
      mBusy = 0; mLast = 1; mErr = 0; mWr = 0; mAcc = 0; mPort = 0;
      mAddr = 0; mWd = 0; mData = 0;
      for (int c = 0; c < 400; c++) begin
        @(posedge clock); #1;
        reset = 1'b0;
        v0 = (c < 396) && ($urandom_range(0, 2) != 0);
        v1 = (c < 396) && ($urandom_range(0, 2) != 0);
        w0 = $urandom_range(0, 1) == 1; w1 = $urandom_range(0, 1) == 1;
        a0 = randAddr(); a1 = randAddr();
        d0 = $urandom; d1 = $urandom;
        applyStimulus(0, v0, w0, a0, d0, v1, w1, a1, d1);
        exp = '0;
        if (mBusy) begin
          rel = c - mAcc;
          if ((mErr && rel == 1) || (!mErr && rel == LAT_A)) begin
            if (mPort == 0) begin exp.r0v = 1; exp.r0d = mData; exp.r0e = mErr; end
            else            begin exp.r1v = 1; exp.r1d = mData; exp.r1e = mErr; end
            mBusy = 0;
          end else if (!mErr) begin
            exp.mw = mWr; exp.mr = !mWr; exp.maddr = mAddr; exp.mwd = mWd;
          end
        end else begin
          win = -1;
          if (v0 && v1) win = (mLast == 0) ? 1 : 0;
          else if (v0)  win = 0;
          else if (v1)  win = 1;
          if (win >= 0) begin
            mBusy = 1; mAcc = c + 1; mLast = win; mPort = win;
            mWr   = (win == 0) ? w0 : w1;
            mAddr = (win == 0) ? a0 : a1;
            mWd   = (win == 0) ? d0 : d1;
            if (win == 0) exp.rdy0 = 1; else exp.rdy1 = 1;
            mErr  = ((mAddr % 4) != 0) || (longint'(mAddr) + 4 > longint'(MEM_BYTES));
            mData = (mErr || mWr) ? 32'h0 : modelLoad(mAddr);
            if (!mErr && mWr) modelStore(mAddr, mWd);
          end
        end
        @(negedge clock);
        checkOutput($sformatf("random cycle %0d", c), sampleOuts(0), exp);
      end
    end

    // Reset in the middle of an ACCESS: no response, strobes drop, and the
    // first tie afterwards goes to port 0 even though port 0 was served last.
    resetCycle();
    @(posedge clock); #1;
    reset = 1'b0;
    applyStimulus(0, 1,0,256,0, 0,0,0,0);
    @(negedge clock);
    checkOutput("abort accept", sampleOuts(0), mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    @(posedge clock); #1;
    reset = 1'b1;
    applyStimulus(0, 0,0,0,0, 0,0,0,0);
    @(negedge clock);
    checkOutput("abort access", sampleOuts(0), mkOuts(0,0,0,1,256,0, 0,0,0, 0,0,0));
    @(posedge clock); #1;
    reset = 1'b0;
    applyStimulus(0, 1,0,260,0, 1,0,264,0);
    @(negedge clock);
    checkOutput("abort after reset", sampleOuts(0), mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    @(posedge clock); #1;
    applyStimulus(0, 0,0,0,0, 0,0,0,0);
    @(negedge clock);
    checkOutput("abort next access", sampleOuts(0), mkOuts(0,0,0,1,260,0, 0,0,0, 0,0,0));
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("abort next resp", sampleOuts(0), mkOuts(0,0,0,0,0,0, 1,modelLoad(260),0, 0,0,0));

    // dutB, three-cycle memory: strobes for three cycles, response at T+4,
    // a held valid is taken again only at T+5.
    addVec(1,0,40,0, 0,0,0,0, mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    addVec(1,0,44,0, 0,0,0,0, mkOuts(0,0,0,1,40,0, 0,0,0, 0,0,0));
    addVec(1,0,44,0, 0,0,0,0, mkOuts(0,0,0,1,40,0, 0,0,0, 0,0,0));
    addVec(1,0,44,0, 0,0,0,0, mkOuts(0,0,0,1,40,0, 0,0,0, 0,0,0));
    addVec(1,0,44,0, 0,0,0,0, mkOuts(0,0,0,0,0,0, 1,32'h64,0, 0,0,0));
    addVec(1,0,44,0, 0,0,0,0, mkOuts(1,0,0,0,0,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,  0,0,0,0, mkOuts(0,0,0,1,44,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,  0,0,0,0, mkOuts(0,0,0,1,44,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,  0,0,0,0, mkOuts(0,0,0,1,44,0, 0,0,0, 0,0,0));
    addVec(0,0,0,0,  0,0,0,0, mkOuts(0,0,0,0,0,0, 1,32'h6E,0, 0,0,0));
    addVec(0,0,0,0,  0,0,0,0, Z);
    runTable("latency3", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
